// File: rtl/stage_write_arb.sv
// Writeback arbiter: main pipe beats queued multdiv results, one registered write per cycle (1-cycle latency).
// md_ready drops only when the holding FIFO is full. Optional forwarding/FIFO-hit ports under WB_FWD_EN.
module stage_write_arb #(
  parameter int DATA_WIDTH  = 32,
  parameter int MD_DEPTH    = 4,
  parameter int RSTATUS_IDX = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mw_valid,
  input  logic [4:0]            opcode,
  input  logic [4:0]            ALU_op,
  input  logic [4:0]            rd,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] pc_plus_1,
  input  logic [DATA_WIDTH-1:0] q_dmem,
  input  logic                  exception,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [4:0]            md_rd,
  input  logic [DATA_WIDTH-1:0] md_result,
  input  logic                  md_exception,
`ifdef WB_FWD_EN
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fifo_hit,
  output logic [DATA_WIDTH-1:0] fifo_data,
`endif
  output logic                  ctrl_writeEnable,
  output logic [4:0]            ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg
);
  localparam int PW = $clog2(MD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] RSTAT = 5'(RSTATUS_IDX);
  localparam logic [CW-1:0] FULL_CNT = CW'(MD_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  localparam logic [4:0] OP_R = 5'b00000, OP_ADDI = 5'b00101, OP_LW = 5'b01000;
  localparam logic [4:0] OP_JAL = 5'b00011, OP_SETX = 5'b10101;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110, ALU_DIV = 5'b00111;

  logic                  main_sel, exc_op;
  logic [4:0]            main_idx;
  logic [DATA_WIDTH-1:0] main_data;

  always_comb begin
    main_sel  = 1'b0;
    exc_op    = 1'b0;
    main_idx  = rd;
    main_data = ALU_result;
    if (mw_valid) begin
      case (opcode)
        OP_R: begin
          main_sel = 1'b1;
          exc_op   = (ALU_op == ALU_ADD) || (ALU_op == ALU_SUB) ||
                     (ALU_op == ALU_MUL) || (ALU_op == ALU_DIV);
        end
        OP_ADDI: begin
          main_sel = 1'b1;
          exc_op   = 1'b1;
        end
        OP_LW: begin
          main_sel  = 1'b1;
          main_data = q_dmem;
        end
        OP_JAL: begin
          main_sel  = 1'b1;
          main_idx  = 5'd31;
          main_data = pc_plus_1;
        end
        OP_SETX: begin
          main_sel = 1'b1;
          main_idx = RSTAT;
        end
        default: main_sel = 1'b0;
      endcase
      if (exc_op && exception) begin
        main_idx  = RSTAT;
        main_data = ONE;
      end
    end
  end

  logic [4:0]            fifo_rd  [MD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_res [MD_DEPTH];
  logic                  fifo_exc [MD_DEPTH];
  logic [CW-1:0]         wr_ptr, rd_ptr, count;
  logic                  empty, push, bypass, mem_push, mem_pop, md_sel;
  logic [4:0]            hd_rd, md_idx, sel_idx;
  logic [DATA_WIDTH-1:0] hd_res, md_data, sel_data;
  logic                  hd_exc;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign md_ready = (count != FULL_CNT);
  assign push     = md_valid && md_ready;
  // An empty FIFO with a free slot hands the incoming result straight through.
  assign bypass   = empty && push && !main_sel;
  assign mem_push = push && !bypass;
  assign mem_pop  = !main_sel && !empty;
  assign md_sel   = !main_sel && (!empty || push);

  assign hd_rd    = empty ? md_rd        : fifo_rd[rd_ptr[PW-1:0]];
  assign hd_res   = empty ? md_result    : fifo_res[rd_ptr[PW-1:0]];
  assign hd_exc   = empty ? md_exception : fifo_exc[rd_ptr[PW-1:0]];
  assign md_idx   = hd_exc ? RSTAT : hd_rd;
  assign md_data  = hd_exc ? ONE : hd_res;
  assign sel_idx  = main_sel ? main_idx : md_idx;
  assign sel_data = main_sel ? main_data : md_data;

  always_ff @(posedge clock) begin
    if (mem_push) begin
      fifo_rd[wr_ptr[PW-1:0]]  <= md_rd;
      fifo_res[wr_ptr[PW-1:0]] <= md_result;
      fifo_exc[wr_ptr[PW-1:0]] <= md_exception;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else begin
      if (mem_push) wr_ptr <= wr_ptr + CW'(1);
      if (mem_pop)  rd_ptr <= rd_ptr + CW'(1);
      ctrl_writeEnable <= (main_sel || md_sel) && (sel_idx != 5'd0);
      ctrl_writeReg    <= (main_sel || md_sel) ? sel_idx : 5'd0;
      data_writeReg    <= (main_sel || md_sel) ? sel_data : '0;
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = ctrl_writeEnable;
  assign fwd_rd    = ctrl_writeReg;
  assign fwd_data  = data_writeReg;

  always_comb begin : hit_scan
    logic [PW-1:0] slot;
    fifo_hit  = 1'b0;
    fifo_data = '0;
    slot      = '0;
    // Oldest to youngest, so the last match wins.
    for (int i = 0; i < MD_DEPTH; i++) begin
      slot = rd_ptr[PW-1:0] + PW'(i);
      if ((CW'(i) < count) && ((fifo_exc[slot] ? RSTAT : fifo_rd[slot]) == rd)) begin
        fifo_hit  = 1'b1;
        fifo_data = fifo_exc[slot] ? ONE : fifo_res[slot];
      end
    end
  end
`endif
endmodule

// File: tb/tb_stage_write_arb.sv
module tb_stage_write_arb;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [4:0] RST_IDX = 5'd30;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mw_valid, exception, md_valid, md_exception, md_ready;
  logic [4:0]    opcode, alu_op, rd, md_rd;
  logic [DW-1:0] alu_result, pc_plus_1, q_dmem, md_result;
  logic          we;
  logic [4:0]    wreg;
  logic [DW-1:0] wdata;
`ifdef WB_FWD_EN
  logic          fwd_valid, fifo_hit;
  logic [4:0]    fwd_rd;
  logic [DW-1:0] fwd_data, fifo_data;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage_write_arb #(.DATA_WIDTH(DW), .MD_DEPTH(DEPTH), .RSTATUS_IDX(30)) dut (
    .clock(clk), .reset(rst_n),
    .mw_valid(mw_valid), .opcode(opcode), .ALU_op(alu_op), .rd(rd),
    .ALU_result(alu_result), .pc_plus_1(pc_plus_1), .q_dmem(q_dmem),
    .exception(exception), .md_valid(md_valid), .md_ready(md_ready),
    .md_rd(md_rd), .md_result(md_result), .md_exception(md_exception),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .fifo_hit(fifo_hit), .fifo_data(fifo_data),
`endif
    .ctrl_writeEnable(we), .ctrl_writeReg(wreg), .data_writeReg(wdata)
  );

  typedef struct {
    logic mwv; logic [4:0] op; logic [4:0] aop; logic [4:0] rdi;
    logic [31:0] alu; logic [31:0] pc1; logic [31:0] qd; logic exc;
    logic mdv; logic [4:0] mdrd; logic [31:0] mdres; logic mdexc;
    logic ewe; logic [4:0] ereg; logic [31:0] edata;
  } vec_t;

  typedef struct { logic [4:0] idx; logic [31:0] data; } ent_t;
  ent_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mw_valid = 0; opcode = 0; alu_op = 0; rd = 0; alu_result = 0;
    pc_plus_1 = 0; q_dmem = 0; exception = 0;
    md_valid = 0; md_rd = 0; md_result = 0; md_exception = 0;
  endtask

  task automatic main_add(input logic [4:0] r, input logic [31:0] v);
    mw_valid = 1; opcode = 5'b00000; alu_op = 5'b00000; rd = r; alu_result = v; exception = 0;
  endtask

  task automatic md_offer(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v; md_rd = r; md_result = d; md_exception = 0;
  endtask

  // Architectural rules for a main-pipe instruction, straight from the ISA table.
  task automatic ref_main(output logic w, output logic [4:0] idx, output logic [31:0] d);
    w = 0; idx = rd; d = alu_result;
    if (mw_valid) begin
      case (opcode)
        5'd0:  begin w = 1; if (exception && (alu_op inside {5'd0, 5'd1, 5'd6, 5'd7})) begin idx = RST_IDX; d = 1; end end
        5'd5:  begin w = 1; if (exception) begin idx = RST_IDX; d = 1; end end
        5'd8:  begin w = 1; d = q_dmem; end
        5'd3:  begin w = 1; idx = 5'd31; d = pc_plus_1; end
        5'd21: begin w = 1; idx = RST_IDX; end
        default: w = 0;
      endcase
    end
  endtask

  vec_t vt[15];

  initial begin
    vt[0]  = '{1, 5'd0,  5'd0, 5'd3,  32'd7,     32'd0,    32'd0,      0, 0, 5'd0, 32'd0,  0, 1, 5'd3,  32'd7};
    vt[1]  = '{1, 5'd5,  5'd0, 5'd5,  32'hFFFF,  32'd0,    32'd0,      1, 0, 5'd0, 32'd0,  0, 1, 5'd30, 32'd1};
    vt[2]  = '{1, 5'd3,  5'd0, 5'd9,  32'd5,     32'h40,   32'd0,      0, 0, 5'd0, 32'd0,  0, 1, 5'd31, 32'h40};
    vt[3]  = '{1, 5'd8,  5'd0, 5'd0,  32'd1,     32'd0,    32'h77,     0, 0, 5'd0, 32'd0,  0, 0, 5'd0,  32'd0};
    vt[4]  = '{1, 5'd8,  5'd0, 5'd6,  32'h11,    32'd0,    32'hABCD,   0, 0, 5'd0, 32'd0,  0, 1, 5'd6,  32'hABCD};
    vt[5]  = '{1, 5'd21, 5'd0, 5'd7,  32'h123,   32'd0,    32'd0,      0, 0, 5'd0, 32'd0,  0, 1, 5'd30, 32'h123};
    vt[6]  = '{1, 5'd0,  5'd1, 5'd8,  32'h99,    32'd0,    32'd0,      1, 0, 5'd0, 32'd0,  0, 1, 5'd30, 32'd1};
    vt[7]  = '{1, 5'd0,  5'd2, 5'd10, 32'h55,    32'd0,    32'd0,      1, 0, 5'd0, 32'd0,  0, 1, 5'd10, 32'h55};
    vt[8]  = '{1, 5'd7,  5'd0, 5'd11, 32'h66,    32'd0,    32'd0,      0, 0, 5'd0, 32'd0,  0, 0, 5'd0,  32'd0};
    vt[9]  = '{0, 5'd0,  5'd0, 5'd12, 32'h66,    32'd0,    32'd0,      0, 0, 5'd0, 32'd0,  0, 0, 5'd0,  32'd0};
    vt[10] = '{0, 5'd0,  5'd0, 5'd0,  32'd0,     32'd0,    32'd0,      0, 1, 5'd4, 32'd9,  0, 1, 5'd4,  32'd9};
    vt[11] = '{0, 5'd0,  5'd0, 5'd0,  32'd0,     32'd0,    32'd0,      0, 1, 5'd4, 32'd77, 1, 1, 5'd30, 32'd1};
    vt[12] = '{1, 5'd0,  5'd6, 5'd13, 32'h1234,  32'd0,    32'd0,      1, 0, 5'd0, 32'd0,  0, 1, 5'd30, 32'd1};
    vt[13] = '{1, 5'd0,  5'd0, 5'd0,  32'd5,     32'd0,    32'd0,      0, 0, 5'd0, 32'd0,  0, 0, 5'd0,  32'd0};
    vt[14] = '{0, 5'd0,  5'd0, 5'd0,  32'd0,     32'd0,    32'd0,      0, 1, 5'd0, 32'd3,  0, 0, 5'd0,  32'd0};

    idle();
    rst_n = 0;
    #2;
    chk("rst_we", 32'(we), 0);
    chk("rst_reg", 32'(wreg), 0);
    chk("rst_data", wdata, 0);
    tick();
    #3 rst_n = 1;
    chk("rst_ready", 32'(md_ready), 1);

    // Single-cycle vectors, FIFO stays empty throughout.
    for (int i = 0; i < 15; i++) begin
      mw_valid = vt[i].mwv; opcode = vt[i].op; alu_op = vt[i].aop; rd = vt[i].rdi;
      alu_result = vt[i].alu; pc_plus_1 = vt[i].pc1; q_dmem = vt[i].qd; exception = vt[i].exc;
      md_valid = vt[i].mdv; md_rd = vt[i].mdrd; md_result = vt[i].mdres; md_exception = vt[i].mdexc;
      tick();
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vt[i].ewe));
      if (vt[i].ewe) begin
        chk($sformatf("vec%0d_reg", i), 32'(wreg), 32'(vt[i].ereg));
        chk($sformatf("vec%0d_data", i), wdata, vt[i].edata);
      end
      chk($sformatf("vec%0d_ready", i), 32'(md_ready), 1);
    end
    idle();
    tick();
    chk("idle_we", 32'(we), 0);

    // Main write and multdiv result in the same cycle.
    main_add(5'd2, 32'd11);
    md_offer(1, 5'd4, 32'd9);
    tick();
    idle();
    chk("conc_reg_main", 32'(wreg), 2);
    chk("conc_we_main", 32'(we), 1);
    tick();
    chk("conc_we_md", 32'(we), 1);
    chk("conc_reg_md", 32'(wreg), 4);
    chk("conc_data_md", wdata, 9);
    tick();
    chk("conc_after_we", 32'(we), 0);

    // Fill the FIFO behind five main writes, then drain.
    for (int k = 0; k < 5; k++) begin
      main_add(5'(20 + k), 32'(100 + k));
      md_offer(k < 4, 5'(1 + k), 32'(200 + k));
      tick();
      chk($sformatf("fill%0d_reg", k), 32'(wreg), 32'(20 + k));
      chk($sformatf("fill%0d_data", k), wdata, 32'(100 + k));
      chk($sformatf("fill%0d_ready", k), 32'(md_ready), (k < 3) ? 1 : 0);
    end
    idle();
    md_offer(1, 5'd9, 32'd999);   // full: must not be accepted even while popping
    tick();
    md_offer(0, 5'd0, 32'd0);
    chk("drain0_reg", 32'(wreg), 1);
    chk("drain0_data", wdata, 200);
    chk("drain0_ready", 32'(md_ready), 1);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk($sformatf("drain%0d_reg", j), 32'(wreg), 32'(1 + j));
      chk($sformatf("drain%0d_data", j), wdata, 32'(200 + j));
    end
    tick();
    chk("drain_done_we", 32'(we), 0);

    // Reset with three queued entries.
    for (int k = 0; k < 3; k++) begin
      main_add(5'(10 + k), 32'(k));
      md_offer(1, 5'(1 + k), 32'(300 + k));
      tick();
    end
    idle();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_reg", 32'(wreg), 0);
    chk("mid_rst_data", wdata, 0);
    tick();
    #2 rst_n = 1;
    chk("post_rst_ready", 32'(md_ready), 1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("post_rst%0d_we", j), 32'(we), 0);
    end

    // Randomized traffic against a queue-based reference.
    mq.delete();
    for (int n = 0; n < 3000; n++) begin
      logic w, push, sel;
      logic [4:0] idx;
      logic [31:0] d;
      ent_t e;
      mw_valid = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 6))
        0: opcode = 5'd0;  1: opcode = 5'd5;  2: opcode = 5'd8;  3: opcode = 5'd3;
        4: opcode = 5'd21; 5: opcode = 5'd7;  default: opcode = 5'd2;
      endcase
      alu_op = 5'($urandom_range(0, 7));
      rd = 5'($urandom); alu_result = $urandom; pc_plus_1 = $urandom; q_dmem = $urandom;
      exception = ($urandom_range(0, 3) == 0);
      md_valid = $urandom_range(0, 1) == 1;
      md_rd = 5'($urandom); md_result = $urandom; md_exception = ($urandom_range(0, 4) == 0);

      chk("rnd_ready", 32'(md_ready), 32'(mq.size() < DEPTH));
      ref_main(w, idx, d);
      push = md_valid && (mq.size() < DEPTH);
      if (push) begin
        e.idx = md_exception ? RST_IDX : md_rd;
        e.data = md_exception ? 32'd1 : md_result;
        mq.push_back(e);
      end
      sel = w;
      if (!w && mq.size() > 0) begin
        e = mq.pop_front();
        sel = 1; idx = e.idx; d = e.data;
      end
      tick();
      chk("rnd_we", 32'(we), 32'(sel && idx != 0));
      if (sel && idx != 0) begin
        chk("rnd_reg", 32'(wreg), 32'(idx));
        chk("rnd_data", wdata, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stage_write_arb.md
STAGE_WRITE_ARB -- requirements
Module: stage_write_arb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the width of register data.
REQ-002 The block SHALL have parameter MD_DEPTH, default 4, giving the multdiv holding FIFO entries; legal values are powers of 2, ≥2.
REQ-003 The block SHALL have parameter RSTATUS_IDX, default 30, giving the status register index.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have the following ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mw_valid  in  1  main-pipe instruction present
- opcode  in  5  main-pipe opcode
- ALU_op  in  5  main-pipe ALU op
- rd  in  5  main-pipe destination
- ALU_result  in  DATA_WIDTH  ALU output
- pc_plus_1  in  DATA_WIDTH  PC+1
- q_dmem  in  DATA_WIDTH  load data
- exception  in  1  main-pipe overflow flag
- md_valid  in  1  multdiv result offered
- md_ready  out  1  multdiv result accepted this cycle
- md_rd  in  5  multdiv destination
- md_result  in  DATA_WIDTH  multdiv result
- md_exception  in  1  multdiv exception
- ctrl_writeEnable  out  1  register-file write strobe
- ctrl_writeReg  out  5  write index
- data_writeReg  out  DATA_WIDTH  write data

Function
REQ-006 Main-pipe decode SHALL be:
- R-type 00000: add ALU_op 00000, sub 00001, mul 00110, div 00111.
- addi 00101; lw 01000; jal 00011; setx 10101.
REQ-007 A main-pipe write SHALL be required for R-type, addi, lw, jal (to r31) and setx (to RSTATUS_IDX).
REQ-008 Main-pipe write data SHALL be:
- lw → q_dmem
- jal → pc_plus_1
- setx → ALU_result (the target)
- otherwise → ALU_result
REQ-009 If exception=1 on add/addi/sub/mul/div, the write SHALL go to RSTATUS_IDX with data {0…,1} in place of rd.
REQ-010 Outputs SHALL be registered: a write selected in cycle N appears on ctrl_* and data_writeReg in cycle N+1, for exactly one cycle.
REQ-011 Writes to index 0 SHALL be suppressed (ctrl_writeEnable=0); a suppressed write still consumes its slot.
REQ-012 md_ready SHALL be 1 when the FIFO is not full, and combinational from FIFO state only.
REQ-013 An md_valid&md_ready handshake SHALL push {md_rd, md_result, md_exception}; an md_exception entry retires to RSTATUS_IDX with data 1.
REQ-014 Priority SHALL be main-pipe write > FIFO head > none.
REQ-015 The FIFO SHALL pop only when no main-pipe write is selected that cycle.
REQ-016 When the FIFO is empty and md_valid=1 with no main-pipe write, the result SHALL bypass the FIFO and be written next cycle (same-cycle push and pop, no occupancy change).
REQ-017 Simultaneous push and pop on a non-empty FIFO SHALL keep occupancy constant.
REQ-018 Pointers SHALL wrap modulo MD_DEPTH.
REQ-019 When the FIFO is full and a pop occurs, md_ready SHALL still be 0 that cycle (no full-bypass).
REQ-020 FIFO order SHALL be strict FIFO, with no reordering against other multdiv results.

Reset
REQ-021 On reset low, the block SHALL clear immediately: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, FIFO empty, md_ready=1 after release.
REQ-022 Reset asserted mid-drain SHALL discard all FIFO entries with no write emitted.
REQ-023 Reset deassertion SHALL be treated synchronously to clock by the surrounding design; the block SHALL need no extra cycles.

Configuration
REQ-024 With macro WB_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_rd (5) and fwd_data (DATA_WIDTH), equal to ctrl_writeEnable, ctrl_writeReg and data_writeReg respectively, plus FIFO-hit outputs fifo_hit (1) and fifo_data (DATA_WIDTH). fifo_hit is asserted when any valid FIFO entry matches input rd, and fifo_data returns the youngest match.
REQ-025 With WB_FWD_EN undefined, these ports SHALL be absent and the behaviour SHALL otherwise be identical.

Verification
REQ-026 The bench SHALL cover:
- add, rd=3, ALU_result=7, exception=0 → cycle+1: we=1, reg=3, data=7.
- addi overflow (exception=1, rd=5) → cycle+1: reg=30, data=1.
- jal with pc_plus_1=0x40 → reg=31, data=0x40; lw rd=0 → we=0.
- md_valid with md_rd=4, result=9 concurrent with main add rd=2 → cycle+1: reg 2; cycle+2: reg 4, data 9.
- 4 md pushes during 5 consecutive main writes → md_ready=0 after the 4th; entries drain in push order once the main pipe idles.
- Reset pulled low with 3 FIFO entries → no further writes; md_ready=1 after release.
